// File: rtl/cac_fns_enc7_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cac_fns_enc7_seq                                           |
// | Description : Sequential 7-bit CAC encoder, greedy MSB-first subtraction |
// |               against latched FNS weights, one code bit per clock.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cac_fns_enc7_seq #(
    parameter int DATA_W = 6,
    parameter int FNS_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    input  logic [FNS_W-1:0]  FNS03,
    input  logic [FNS_W-1:0]  FNS04,
    input  logic [FNS_W-1:0]  FNS05,
    input  logic [FNS_W-1:0]  FNS06,
    input  logic [FNS_W-1:0]  FNS07,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        codeout,
    output logic              enc_err
);

    localparam int c_CMP_W = (DATA_W > FNS_W) ? DATA_W : FNS_W;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ENC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_residual;
    logic [2:0]        r_idx;
    logic [6:0]        r_code;
    logic [6:0]        r_codeout;
    logic              r_enc_err;
    logic [FNS_W-1:0]  r_fns03;
    logic [FNS_W-1:0]  r_fns04;
    logic [FNS_W-1:0]  r_fns05;
    logic [FNS_W-1:0]  r_fns06;
    logic [FNS_W-1:0]  r_fns07;

    logic [c_CMP_W-1:0] w_weight;
    logic [c_CMP_W-1:0] w_res_ext;
    logic [c_CMP_W-1:0] w_res_nxt;
    logic               w_take;
    logic [6:0]         w_code_nxt;
    logic               w_accept;

    // Bits 0 and 1 carry a fixed weight of one; bits 2..6 use the latched weights.
    always_comb begin
        w_weight = c_CMP_W'(1);
        case (r_idx)
            3'd2:    w_weight = c_CMP_W'(r_fns03);
            3'd3:    w_weight = c_CMP_W'(r_fns04);
            3'd4:    w_weight = c_CMP_W'(r_fns05);
            3'd5:    w_weight = c_CMP_W'(r_fns06);
            3'd6:    w_weight = c_CMP_W'(r_fns07);
            default: w_weight = c_CMP_W'(1);
        endcase
    end

    always_comb begin
        w_res_ext         = c_CMP_W'(r_residual);
        w_take            = (w_res_ext >= w_weight);
        w_res_nxt         = w_take ? (w_res_ext - w_weight) : w_res_ext;
        w_code_nxt        = r_code;
        w_code_nxt[r_idx] = w_take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ENC;
                end
            end
            c_ENC: begin
                if (r_idx == 3'd0) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_residual <= '0;
            r_idx      <= 3'd6;
            r_code     <= '0;
            r_codeout  <= '0;
            r_enc_err  <= 1'b0;
            r_fns03    <= '0;
            r_fns04    <= '0;
            r_fns05    <= '0;
            r_fns06    <= '0;
            r_fns07    <= '0;
        end else if (w_accept) begin
            r_residual <= datain;
            r_idx      <= 3'd6;
            r_code     <= '0;
            r_fns03    <= FNS03;
            r_fns04    <= FNS04;
            r_fns05    <= FNS05;
            r_fns06    <= FNS06;
            r_fns07    <= FNS07;
        end else if (r_state == c_ENC) begin
            // A taken bit never exceeds the residual, so the narrowing is lossless.
            r_residual <= w_res_nxt[DATA_W-1:0];
            r_code     <= w_code_nxt;
            if (r_idx == 3'd0) begin
                r_codeout <= w_code_nxt;
                r_enc_err <= (w_res_nxt != '0);
            end else begin
                r_idx <= r_idx - 3'd1;
            end
        end
    end

    assign codeout = r_codeout;
    assign enc_err = r_enc_err;

endmodule
`default_nettype wire

// File: tb/tb_cac_fns_enc7_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cac_fns_enc7_seq                                        |
// | Description : Directed and random bench for the 7-bit CAC encoder.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cac_fns_enc7_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] datain;
    logic [4:0] FNS03, FNS04, FNS05, FNS06, FNS07;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] codeout;
    logic       enc_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]  data;
        logic [24:0] wts;
        logic [6:0]  code;
        logic        err;
    } exp_t;

    exp_t sb[$];

    localparam logic [24:0] c_W_STD = {5'd13, 5'd8, 5'd5, 5'd3, 5'd2};

    always #5 clk = ~clk;

    cac_fns_enc7_seq #(.DATA_W(6), .FNS_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .FNS03     (FNS03),
        .FNS04     (FNS04),
        .FNS05     (FNS05),
        .FNS06     (FNS06),
        .FNS07     (FNS07),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
        .enc_err   (enc_err)
    );

    function automatic int weight_of(input logic [24:0] wts, input int i);
        if (i < 2) return 1;
        return int'(wts[(i-2)*5 +: 5]);
    endfunction

    // Greedy MSB-first reference encoder.
    function automatic exp_t model(input logic [5:0] d, input logic [24:0] wts);
        exp_t e;
        int   res;
        res    = int'(d);
        e.data = d;
        e.wts  = wts;
        e.code = '0;
        for (int i = 6; i >= 0; i--) begin
            if (res >= weight_of(wts, i)) begin
                e.code[i] = 1'b1;
                res       = res - weight_of(wts, i);
            end
        end
        e.err = (res != 0);
        return e;
    endfunction

    function automatic int decode(input logic [6:0] c, input logic [24:0] wts);
        int s = 0;
        for (int i = 0; i < 7; i++) if (c[i]) s += weight_of(wts, i);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic [24:0] wts);
        {FNS07, FNS06, FNS05, FNS04, FNS03} = wts;
    endtask

    task automatic send(input logic [5:0] d, input logic [24:0] wts, input bit scramble);
        datain = d;
        drive_w(wts);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sb.push_back(model(d, wts));
        if (scramble) drive_w({5'd8, 5'd5, 5'd3, 5'd2, 5'd1});
    endtask

    task automatic collect();
        int   cyc = 0;
        exp_t e;
        while (out_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("latency", 32'(cyc), 32'd7);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("codeout", 32'(codeout), 32'(e.code));
            check("enc_err", 32'(enc_err), 32'(e.err));
            if (!e.err) check("decode_sum", 32'(decode(codeout, e.wts)), 32'(e.data));
        end
        if (out_ready) begin
            step();
            check("handoff_out_valid", 32'(out_valid), 32'd0);
            check("handoff_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        datain    = '0;
        drive_w(c_W_STD);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_codeout", 32'(codeout), 32'd0);
        check("rst_enc_err", 32'(enc_err), 32'd0);
        rst_n = 1'b1;
        step();

        send(6'd20, c_W_STD, 1'b0); collect();
        check("t1_code", 32'(codeout), 32'b1010100);
        send(6'd7, c_W_STD, 1'b0);  collect();
        check("t2_code", 32'(codeout), 32'b0010100);
        send(6'd0, c_W_STD, 1'b0);  collect();
        check("t2_zero", 32'(codeout), 32'd0);
        send(6'd33, c_W_STD, 1'b0); collect();
        check("t3_33_code", 32'(codeout), 32'b1111111);
        check("t3_33_err", 32'(enc_err), 32'd0);
        send(6'd34, c_W_STD, 1'b0); collect();
        check("t3_34_code", 32'(codeout), 32'b1111111);
        check("t3_34_err", 32'(enc_err), 32'd1);

        // Back-pressure: outputs held, new word refused.
        out_ready = 1'b0;
        send(6'd20, c_W_STD, 1'b0);
        collect();
        datain   = 6'd7;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_codeout", 32'(codeout), 32'b1010100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Weights changed mid-encode must not affect the result.
        send(6'd20, c_W_STD, 1'b1); collect();
        check("t5_latched", 32'(codeout), 32'b1010100);
        drive_w(c_W_STD);

        // Reset pulse in the third encode cycle drops the word.
        send(6'd20, c_W_STD, 1'b0);
        void'(sb.pop_back());
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_codeout", 32'(codeout), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        step();
        send(6'd7, c_W_STD, 1'b0); collect();
        check("t6_next_code", 32'(codeout), 32'b0010100);

        for (int n = 0; n < 15; n++) begin
            send(6'($urandom_range(0, 63)), 25'($urandom), 1'b0);
            collect();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
